stream_arb_ctrl: RTL and testbench

- Round-robin arbiter and sequencer that shares one serial Moore-type detector among NREQ bit-serial requesters.
- Grants one requester per frame, clears the detector to its initial state, and streams FRAME_LEN bits from the granted requester into it.
- Captures the detector output at end of frame and returns it with the requester ID.
- Sits between the requester front-ends and the single shared detector instance.

---
 rtl/stream_arb_ctrl_pkg.sv | 24 ++
 rtl/stream_arb_ctrl_rr_pick.sv | 38 +++
 rtl/stream_arb_ctrl.sv | 147 ++++++++++++++
 tb/tb_stream_arb_ctrl.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_ctrl_pkg.sv
// rtl/stream_arb_ctrl_pkg.sv - shared types and constants for the stream arbiter
//
// Purpose: FSM state encoding, default sizing constants and the modulo helper
//          used by the round-robin selector.
// Ports:   none (package).

package stream_arb_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CLR  = 2'b01,
        ST_XFER = 2'b10,
        ST_DONE = 2'b11
    } arb_state_t;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_FRAME_LEN = 8;

    // Index of the requester 'off' positions after 'base', wrapping at n.
    function automatic int rr_wrap(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/stream_arb_ctrl_rr_pick.sv
// rtl/stream_arb_ctrl_rr_pick.sv - combinational round-robin requester selector
//
// Purpose: picks the first set request searching last+1, last+2, ... modulo NREQ.
// Ports:   req     - per-requester request level
//          last    - index of the most recently served requester
//          gnt     - one-hot selection (all zero when nothing requests)
//          idx     - binary index of the selection
//          any_req - at least one request is set

module rr_pick
    import stream_arb_ctrl_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] idx,
    output logic            any_req
);

    always_comb begin
        gnt     = '0;
        idx     = '0;
        any_req = |req;
        // Walk from the farthest offset (last itself) towards the nearest,
        // so the requester closest after 'last' overwrites any earlier hit.
        for (int off = NREQ; off >= 1; off--) begin
            if (req[rr_wrap(int'(last), off, NREQ)]) begin
                gnt = '0;
                gnt[rr_wrap(int'(last), off, NREQ)] = 1'b1;
                idx = ID_W'(rr_wrap(int'(last), off, NREQ));
            end
        end
    end

endmodule

// File: rtl/stream_arb_ctrl.sv
// rtl/stream_arb_ctrl.sv - round-robin sequencer sharing one serial detector
//
// Purpose: grants one requester per frame, clears the shared detector, streams
//          FRAME_LEN bits from the granted requester into it and returns the
//          detector output together with the requester index.
// Ports:   clk, rst          - clock, asynchronous active-low reset
//          req, bit_in       - per-requester request level and serial data
//          det_q             - shared detector Moore output
//          det_din/en/clr    - detector data, advance enable, synchronous clear
//          gnt, busy         - one-hot grant (CLR..DONE), not-idle flag
//          done, result, result_id - one-cycle result strobe with payload

module stream_arb_ctrl
    import stream_arb_ctrl_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int ID_W      = $clog2(NREQ),
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int CNT_W     = $clog2(FRAME_LEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] bit_in,
    input  logic            det_q,
    output logic            det_din,
    output logic            det_en,
    output logic            det_clr,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic            done,
    output logic            result,
    output logic [ID_W-1:0] result_id
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NREQ - 1);

    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0] idx_q, idx_d;
    logic [ID_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            result_q, result_d;
    logic [ID_W-1:0] result_id_q, result_id_d;

    logic [NREQ-1:0] pick_gnt;
    logic [ID_W-1:0] pick_idx;
    logic            pick_any;

    rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req     (req),
        .last    (last_q),
        .gnt     (pick_gnt),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        idx_d       = idx_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        result_id_d = result_id_q;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // req is only looked at here; later changes cannot abort a frame.
                if (pick_any) begin
                    gnt_d   = pick_gnt;
                    idx_d   = pick_idx;
                    state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                cnt_d   = '0;
                state_d = ST_XFER;
            end
            ST_XFER: begin
                // Hold on the last bit instead of wrapping; CLR reloads it.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                // The detector advanced on the final XFER edge, so det_q now
                // reflects all FRAME_LEN bits.
                result_d    = det_q;
                result_id_d = idx_q;
                done_d      = 1'b1;
                last_d      = idx_q;
                gnt_d       = '0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            idx_q       <= '0;
            last_q      <= LAST_RST;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= 1'b0;
            result_id_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            result_id_q <= result_id_d;
        end
    end

    // Detector controls decode straight from registered state so they are
    // mutually exclusive by construction.
    assign det_clr   = (state_q == ST_CLR);
    assign det_en    = (state_q == ST_XFER);
    assign det_din   = det_en & bit_in[idx_q];

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign result_id = result_id_q;

endmodule

// File: tb/tb_stream_arb_ctrl.sv
// tb/tb_stream_arb_ctrl.sv - self-checking bench for stream_arb_ctrl

module tb_stream_arb_ctrl;

    localparam int NREQ      = 4;
    localparam int ID_W      = 2;
    localparam int FRAME_LEN = 8;
    localparam int CNT_W     = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] bit_in;
    logic            det_q;
    logic            det_din, det_en, det_clr;
    logic [NREQ-1:0] gnt;
    logic            busy, done, result;
    logic [ID_W-1:0] result_id;

    stream_arb_ctrl #(
        .NREQ      (NREQ),
        .ID_W      (ID_W),
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .bit_in    (bit_in),
        .det_q     (det_q),
        .det_din   (det_din),
        .det_en    (det_en),
        .det_clr   (det_clr),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_id (result_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Requester front-ends: each presents bit 'ptr' of its frame pattern.
    // Detector model: parity of streamed bits, optionally overridden.
    logic [FRAME_LEN-1:0] pat [NREQ];
    int   ptr;
    logic dstate;
    logic force_en  = 1'b0;
    logic force_val = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr    <= 0;
            dstate <= 1'b0;
        end else if (det_clr) begin
            ptr    <= 0;
            dstate <= 1'b0;
        end else if (det_en) begin
            ptr    <= ptr + 1;
            dstate <= dstate ^ det_din;
        end
    end

    always_comb begin
        bit_in = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (ptr < FRAME_LEN) bit_in[r] = pat[r][ptr];
        end
    end

    assign det_q = force_en ? force_val : dstate;

    typedef struct {
        logic [ID_W-1:0] id;
        logic            res;
    } exp_t;
    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    task automatic wait_done(input int budget, output bit ok, output int at_cyc);
        ok     = 1'b0;
        at_cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok     = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (gnt !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_gnt_busy: gnt=%b busy=%b required gnt=0000 busy=0", gnt, busy);
        end
        checks++;
        if (det_en !== 1'b0 || det_clr !== 1'b0 || det_din !== 1'b0) begin
            failures++;
            $display("FAIL reset_det: en=%b clr=%b din=%b required 0 0 0", det_en, det_clr, det_din);
        end
        checks++;
        if (done !== 1'b0 || result !== 1'b0 || result_id !== '0) begin
            failures++;
            $display("FAIL reset_result: done=%b result=%b id=%0d required 0 0 0", done, result, result_id);
        end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (gnt !== '0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL idle_no_req: cycle %0d gnt=%b busy=%b required 0000 0", i, gnt, busy);
            end
        end
    endtask

    task automatic test_single();
        logic [FRAME_LEN-1:0] p;
        exp_t e;
        pat[2] = 8'b1100_1101;   // streamed LSB first: 1,0,1,1,0,0,1,1
        p      = pat[2];
        sb.push_back('{id: 2'd2, res: ^p});
        req = 4'b0100;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0100 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_grant: gnt=%b busy=%b required 0100 1", gnt, busy);
        end
        checks++;
        if (det_clr !== 1'b1 || det_en !== 1'b0) begin
            failures++;
            $display("FAIL single_clr: clr=%b en=%b required 1 0", det_clr, det_en);
        end
        req = '0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            @(negedge clk);
            checks++;
            if (det_en !== 1'b1 || det_clr !== 1'b0 || det_din !== p[i]) begin
                failures++;
                $display("FAIL single_bit%0d: en=%b clr=%b din=%b required 1 0 %b", i, det_en, det_clr, det_din, p[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (det_en !== 1'b0 || done !== 1'b0 || gnt !== 4'b0100) begin
            failures++;
            $display("FAIL single_done_state: en=%b done=%b gnt=%b required 0 0 0100", det_en, done, gnt);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL single_done_latency: done=%b required 1 at cycle 11", done);
        end else begin
            e = sb.pop_front();
            checks++;
            if (result_id !== e.id || result !== e.res) begin
                failures++;
                $display("FAIL single_result: id=%0d res=%b required %0d %b", result_id, result, e.id, e.res);
            end
        end
        checks++;
        if (gnt !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_release: gnt=%b busy=%b required 0000 0", gnt, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL single_done_pulse: done=%b required 0", done);
        end
    endtask

    task automatic test_round_robin();
        int   order [5] = '{0, 1, 2, 3, 0};
        int   prev_cyc;
        int   at;
        bit   ok;
        exp_t e;
        logic [NREQ-1:0] eg;
        do_reset();
        pat[0] = 8'hA5;
        pat[1] = 8'h01;
        pat[2] = 8'hCD;
        pat[3] = 8'h00;
        for (int f = 0; f < 5; f++) begin
            sb.push_back('{id: ID_W'(order[f]), res: ^pat[order[f]]});
        end
        prev_cyc = 0;
        req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            ok = 1'b0;
            at = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (det_clr === 1'b1) begin
                    eg = 4'b0001 << order[f];
                    checks++;
                    if (gnt !== eg) begin
                        failures++;
                        $display("FAIL rr_grant%0d: gnt=%b required %b", f, gnt, eg);
                    end
                end
                if (done === 1'b1) begin
                    ok = 1'b1;
                    at = cyc;
                    break;
                end
            end
            if (f == 4) req = '0;
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL rr_timeout%0d: no done within 30 cycles, required done", f);
            end else begin
                e = sb.pop_front();
                checks++;
                if (result_id !== e.id || result !== e.res) begin
                    failures++;
                    $display("FAIL rr_result%0d: id=%0d res=%b required %0d %b", f, result_id, result, e.id, e.res);
                end
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL rr_idle%0d: busy=%b required 0", f, busy);
                end
                if (f > 0) begin
                    checks++;
                    if (at - prev_cyc != FRAME_LEN + 3) begin
                        failures++;
                        $display("FAIL rr_period%0d: gap=%0d required %0d", f, at - prev_cyc, FRAME_LEN + 3);
                    end
                end
                prev_cyc = at;
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rr_stop: busy=%b required 0", busy);
        end
    endtask

    task automatic test_result_capture();
        bit   ok;
        int   at;
        exp_t e;
        force_en  = 1'b1;
        force_val = 1'b1;
        sb.push_back('{id: 2'd3, res: 1'b1});
        req = 4'b1000;
        @(negedge clk);
        req = '0;
        wait_done(20, ok, at);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL cap1_timeout: no done, required done");
        end else begin
            e = sb.pop_front();
            checks++;
            if (result !== e.res || result_id !== e.id) begin
                failures++;
                $display("FAIL cap1_result: res=%b id=%0d required %b %0d", result, result_id, e.res, e.id);
            end
        end
        force_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (result !== 1'b1) begin
                failures++;
                $display("FAIL cap_hold%0d: res=%b required 1", i, result);
            end
        end
        sb.push_back('{id: 2'd3, res: 1'b0});
        req = 4'b1000;
        @(negedge clk);
        req = '0;
        wait_done(20, ok, at);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL cap0_timeout: no done, required done");
        end else begin
            e = sb.pop_front();
            checks++;
            if (result !== e.res || result_id !== e.id) begin
                failures++;
                $display("FAIL cap0_result: res=%b id=%0d required %b %0d", result, result_id, e.res, e.id);
            end
        end
        force_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        int   en_cnt;
        bit   ok;
        exp_t e;
        pat[1] = 8'h01;
        sb.push_back('{id: 2'd1, res: ^pat[1]});
        en_cnt = 0;
        ok     = 1'b0;
        req    = 4'b0010;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (det_en === 1'b1) begin
                en_cnt++;
                if (en_cnt == 3) req = '0;
            end
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL abort_timeout: no done, required done");
        end else begin
            e = sb.pop_front();
            checks++;
            if (result_id !== e.id || result !== e.res) begin
                failures++;
                $display("FAIL abort_result: id=%0d res=%b required %0d %b", result_id, result, e.id, e.res);
            end
        end
        checks++;
        if (en_cnt != FRAME_LEN) begin
            failures++;
            $display("FAIL abort_bits: det_en cycles=%0d required %0d", en_cnt, FRAME_LEN);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        bit   ok;
        int   at;
        exp_t e;
        logic [NREQ-1:0] eg;
        req = 4'b0100;
        @(negedge clk);
        req = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || gnt !== '0 || det_en !== 1'b0 || det_clr !== 1'b0) begin
            failures++;
            $display("FAIL midrst_drop: busy=%b gnt=%b en=%b clr=%b required 0 0000 0 0", busy, gnt, det_en, det_clr);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL midrst_done%0d: done=%b required 0", i, done);
            end
        end
        sb.push_back('{id: 2'd0, res: ^pat[0]});
        sb.push_back('{id: 2'd3, res: ^pat[3]});
        req = 4'b1001;
        rst = 1'b1;
        for (int f = 0; f < 2; f++) begin
            ok = 1'b0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (det_clr === 1'b1 && sb.size() > 0) begin
                    eg = 4'b0001 << sb[0].id;
                    checks++;
                    if (gnt !== eg) begin
                        failures++;
                        $display("FAIL midrst_grant%0d: gnt=%b required %b", f, gnt, eg);
                    end
                end
                if (done === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
            end
            req = (f == 0) ? 4'b1000 : 4'b0000;
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL midrst_timeout%0d: no done, required done", f);
            end else begin
                e = sb.pop_front();
                checks++;
                if (result_id !== e.id || result !== e.res) begin
                    failures++;
                    $display("FAIL midrst_result%0d: id=%0d res=%b required %0d %b", f, result_id, result, e.id, e.res);
                end
            end
        end
        wait_done(3, ok, at);
        checks++;
        if (ok) begin
            failures++;
            $display("FAIL midrst_extra: unexpected done at cycle %0d, required none", at);
        end
    endtask

    always @(negedge clk) begin
        if (det_en === 1'b1 && det_clr === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL en_clr_overlap: en=1 clr=1 required exclusive");
        end
    end

    initial begin
        for (int r = 0; r < NREQ; r++) pat[r] = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_result_capture();
        test_abort();
        test_mid_reset();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_empty: %0d entries left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
